// File: rtl/wb_arbiter_pkg.sv
// ============================================================================
// Module   : wb_arbiter_pkg
// Brief    : Shared widths and entry type for the writeback arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Fallback values; a project-wide define.v included earlier takes precedence.
`ifndef RegWidth
`define RegWidth 32
`endif
`ifndef RegAddrWidth
`define RegAddrWidth 5
`endif

package wb_arbiter_pkg;

  localparam int c_reg_w  = `RegWidth;
  localparam int c_addr_w = `RegAddrWidth;

  typedef logic [c_addr_w-1:0] reg_addr_t;
  typedef logic [c_reg_w-1:0]  reg_data_t;

  typedef struct packed {
    logic      live;
    reg_addr_t addr;
    reg_data_t data;
  } ll_entry_t;

  // r0 is hardwired, so writes to it are suppressed along with stale entries.
  function automatic logic is_real_write(input logic live, input reg_addr_t addr);
    return live && (addr != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_ll_queue.sv
// ============================================================================
// Module   : wb_ll_queue
// Brief    : DEPTH-entry FIFO of long-latency results with per-entry live bit
//            and an address-match invalidate port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_ll_queue
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  ll_entry_t              push_entry,
  input  logic                   pop,
  input  logic                   inv_en,
  input  reg_addr_t              inv_addr,
  output ll_entry_t              head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [DEPTH-1:0]   r_live;
  logic [DEPTH-1:0]   w_live_nxt;
  reg_addr_t          r_addr [DEPTH];
  reg_data_t          r_data [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      r_addr[r_wr_ptr] <= push_entry.addr;
      r_data[r_wr_ptr] <= push_entry.data;
    end
  end

  // A fresh push overrides any invalidate aimed at the same slot; the caller
  // already folds the same-cycle address match into push_entry.live.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_live
      assign w_live_nxt[i] =
          (push && (r_wr_ptr == c_ptr_w'(i))) ? push_entry.live :
          (inv_en && (r_addr[i] == inv_addr)) ? 1'b0 : r_live[i];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) r_live <= '0;
    else      r_live <= w_live_nxt;
  end

  assign head  = {r_live[r_rd_ptr], r_addr[r_rd_ptr], r_data[r_rd_ptr]};
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module   : wb_arbiter
// Brief    : Register-file writeback arbiter: main pipeline has priority,
//            long-latency results are queued and issued in idle slots.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_LIM = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pipe_wb_en,
  input  logic [c_addr_w-1:0] pipe_wb_addr,
  input  logic [c_reg_w-1:0]  pipe_wb_data,
  input  logic                ll_valid,
  output logic                ll_ready,
  input  logic [c_addr_w-1:0] ll_addr,
  input  logic [c_reg_w-1:0]  ll_data,
  output logic                write_en,
  output logic [c_addr_w-1:0] write_addr,
  output logic [c_reg_w-1:0]  write_data,
  output logic                pipe_stall
);

  localparam int c_cnt_w = $clog2(DEPTH) + 1;
  localparam int c_age_w = $clog2(STARVE_LIM + 1);
  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
  localparam logic [c_age_w-1:0] c_age_lim = c_age_w'(STARVE_LIM);

  logic [c_cnt_w-1:0] w_count;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  ll_entry_t          w_push_entry;
  ll_entry_t          w_head;

  logic               r_write_en;
  reg_addr_t          r_write_addr;
  reg_data_t          r_write_data;
  logic               r_pipe_stall;
  logic [c_age_w-1:0] r_age;

  assign ll_ready = (w_count < c_depth);
  assign w_empty  = (w_count == '0);
  assign w_push   = ll_valid && ll_ready;
  // Pop decision uses the registered count, so a push into an empty queue waits a cycle.
  assign w_pop    = !pipe_wb_en && !w_empty;

  assign w_push_entry.live = !(pipe_wb_en && (ll_addr == pipe_wb_addr));
  assign w_push_entry.addr = ll_addr;
  assign w_push_entry.data = ll_data;

  wb_ll_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .inv_en     (pipe_wb_en),
    .inv_addr   (pipe_wb_addr),
    .head       (w_head),
    .count      (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_write_en   <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
    end else if (pipe_wb_en) begin
      r_write_en   <= is_real_write(1'b1, pipe_wb_addr);
      r_write_addr <= pipe_wb_addr;
      r_write_data <= pipe_wb_data;
    end else if (w_pop) begin
      r_write_en   <= is_real_write(w_head.live, w_head.addr);
      r_write_addr <= w_head.addr;
      r_write_data <= w_head.data;
    end else begin
      r_write_en   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_age        <= '0;
      r_pipe_stall <= 1'b0;
    end else begin
      if (w_pop || w_empty)      r_age <= '0;
      else if (r_age != c_age_lim) r_age <= r_age + c_age_w'(1);
      r_pipe_stall <= (r_age == c_age_lim) && !w_pop;
    end
  end

  assign write_en   = r_write_en;
  assign write_addr = r_write_addr;
  assign write_data = r_write_data;
  assign pipe_stall = r_pipe_stall;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Directed plus random stimulus against a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_LIM = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pipe_wb_en = 1'b0;
  logic [4:0]  pipe_wb_addr = '0;
  logic [31:0] pipe_wb_data = '0;
  logic        ll_valid = 1'b0;
  logic        ll_ready;
  logic [4:0]  ll_addr = '0;
  logic [31:0] ll_data = '0;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        pipe_stall;

  wb_arbiter #(
    .DEPTH      (DEPTH),
    .STARVE_LIM (STARVE_LIM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_wb_en   (pipe_wb_en),
    .pipe_wb_addr (pipe_wb_addr),
    .pipe_wb_data (pipe_wb_data),
    .ll_valid     (ll_valid),
    .ll_ready     (ll_ready),
    .ll_addr      (ll_addr),
    .ll_data      (ll_data),
    .write_en     (write_en),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .pipe_stall   (pipe_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        live;
    bit [4:0]  addr;
    bit [31:0] data;
  } ent_t;

  ent_t      q[$];
  int        wait_cyc = 0;
  bit        exp_we = 0;
  bit [4:0]  exp_wa = '0;
  bit [31:0] exp_wd = '0;
  bit        exp_stall = 0;
  bit        exp_zero = 0;
  bit        started = 0;
  int        n_err = 0;
  int        n_chk = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check what the previous edge produced, drive new inputs, advance the model.
  task automatic step(input bit rst_v, input bit pe, input bit [4:0] pa, input bit [31:0] pd,
                      input bit lv, input bit [4:0] la, input bit [31:0] ld);
    bit   pushing;
    bit   popping;
    ent_t e;
    @(negedge clk);
    if (started) begin
      chk_val("write_en", write_en, exp_we);
      if (exp_we) begin
        chk_val("write_addr", write_addr, exp_wa);
        chk_val("write_data", write_data, exp_wd);
      end
      if (exp_zero) begin
        chk_val("rst_write_addr", write_addr, 0);
        chk_val("rst_write_data", write_data, 0);
      end
      chk_val("pipe_stall", pipe_stall, exp_stall);
      chk_val("ll_ready", ll_ready, (q.size() < DEPTH));
    end
    rst = rst_v; pipe_wb_en = pe; pipe_wb_addr = pa; pipe_wb_data = pd;
    ll_valid = lv; ll_addr = la; ll_data = ld;

    if (!rst_v) begin
      q.delete();
      wait_cyc  = 0;
      exp_we    = 0;
      exp_stall = 0;
      exp_zero  = 1;
      started   = 1;
    end else begin
      exp_zero = 0;
      pushing  = lv && (q.size() < DEPTH);
      popping  = !pe && (q.size() > 0);
      exp_stall = !popping && (wait_cyc >= STARVE_LIM);
      wait_cyc  = (popping || q.size() == 0) ? 0 : wait_cyc + 1;
      if (pe) begin
        foreach (q[i]) if (q[i].addr == pa) q[i].live = 0;
        exp_we = (pa != 0); exp_wa = pa; exp_wd = pd;
      end else if (popping) begin
        e = q.pop_front();
        exp_we = e.live && (e.addr != 0); exp_wa = e.addr; exp_wd = e.data;
      end else begin
        exp_we = 0;
      end
      if (pushing) begin
        e.live = !(pe && la == pa); e.addr = la; e.data = ld;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // pipe-only write
    step(1, 1, 5, 32'h1234, 0, 0, 0);
    idle(2);
    // long-latency write into idle pipe
    step(1, 0, 0, 0, 1, 7, 32'hA5A5);
    idle(3);
    // fill queue under continuous pipe traffic, then release
    step(1, 1, 1, 32'h11, 1, 3, 32'h33);
    step(1, 1, 2, 32'h22, 1, 4, 32'h44);
    for (int i = 0; i < 5; i++) step(1, 1, 5'(10 + i), 32'(i), 1, 6, 32'h66);
    idle(4);
    // younger pipe write to the same register kills the queued entry
    step(1, 1, 1, 32'h5, 1, 9, 32'h1);
    step(1, 1, 9, 32'h2, 0, 0, 0);
    idle(3);
    // zero register
    step(1, 1, 0, 32'hFFFF, 0, 0, 0);
    idle(1);
    // reset with two queued entries
    step(1, 1, 2, 32'h7, 1, 12, 32'hC);
    step(1, 1, 3, 32'h8, 1, 13, 32'hD);
    step(0, 0, 0, 0, 0, 0, 0);
    idle(4);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 55),
           5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 99) < 40),
           5'($urandom_range(0, 7)), $urandom);
    idle(6);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters: DEPTH, default 2, long-latency queue entries (power of 2, >=2); STARVE_LIM, default 3, head-wait cycles before stall request.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset (0 = reset).
REQ-004 pipe_wb_en  input  1  main-pipeline writeback valid; always accepted, no backpressure.
REQ-005 pipe_wb_addr  input  5  main-pipeline destination register.
REQ-006 pipe_wb_data  input  32  main-pipeline result.
REQ-007 ll_valid  input  1  long-latency unit (mul/div) result valid.
REQ-008 ll_ready  output  1  queue can accept; transfer when ll_valid && ll_ready.
REQ-009 ll_addr  input  5  long-latency destination register.
REQ-010 ll_data  input  32  long-latency result.
REQ-011 write_en  output  1  regfile write enable, registered.
REQ-012 write_addr  output  5  regfile write address, registered.
REQ-013 write_data  output  32  regfile write data, registered.
REQ-014 pipe_stall  output  1  request to freeze main pipeline, registered.

Function
REQ-015 ll_ready SHALL equal (count < DEPTH), from registered count only, independent of same-cycle pop.
REQ-016 Accepted ll transfer SHALL push {live=1, addr, data} at queue tail; FIFO order preserved.
REQ-017 Arbitration per cycle: pipe_wb_en=1 -> issue pipe write; else queue non-empty -> pop head and issue it; else issue nothing.
REQ-018 Issued write SHALL appear on write_en/addr/data exactly one cycle after the arbitration cycle.
REQ-019 Issued write with addr 0, or popped entry with live=0, SHALL drive write_en=0 that cycle (entry still consumed); write_addr/write_data don't-care.
REQ-020 Ordering: when pipe_wb_en=1, every queued entry with addr == pipe_wb_addr SHALL have live cleared that cycle (pipe write is younger, must win).
REQ-021 Same-cycle ll push with ll_addr == pipe_wb_addr and pipe_wb_en=1 SHALL be pushed with live=0.
REQ-022 Push and pop in same cycle SHALL leave count unchanged; push into empty queue SHALL NOT be popped in the same cycle (earliest pop next cycle).
REQ-023 age counter: resets to 0 on any pop or when queue empty; increments, saturating at STARVE_LIM, each cycle head is present and not popped.
REQ-024 pipe_stall SHALL be 1 in the cycle after age reaches STARVE_LIM, and fall the cycle after the head pops.
REQ-025 If pipe_wb_en=1 while pipe_stall=1, pipe priority SHALL still hold (no data loss); stall remains asserted.
REQ-026 Pointers SHALL wrap modulo DEPTH; count width clog2(DEPTH)+1.

Reset
REQ-027 rst=0 at a clock edge SHALL clear count, pointers, age, all live bits, write_en, pipe_stall, write_addr, write_data to 0.
REQ-028 Reset mid-operation SHALL discard all queued entries without issuing them; ll_ready=1 on the first cycle after reset release.
REQ-029 Queue data storage needs no reset.

Structure
REQ-030 Register widths (32) and address width (5) SHALL come from the shared define.v macros RegWidth/RegAddrWidth; no local literals.
REQ-031 One sub-module wb_ll_queue (DEPTH-entry FIFO with per-entry live bit and address-match invalidate port) SHALL hold the queue; arbitration, age and output registers stay in wb_arbiter.

Verification
REQ-032 Pipe only: pipe_wb_en=1, addr 5, data 0x1234 -> next cycle write_en=1, write_addr=5, write_data=0x1234.
REQ-033 LL only, idle pipe: ll push addr 7 data 0xA5A5 at cycle t -> write_en=1 addr 7 at t+2; ll_ready stays 1.
REQ-034 Fill: two ll pushes while pipe_wb_en=1 continuously -> ll_ready=0 after second; pipe_stall=1 after head waits 3 cycles; drop pipe_wb_en -> head issued next cycle, pipe_stall falls, order 1st then 2nd.
REQ-035 Ordering: queue entry addr 9 data 0x1, then pipe write addr 9 data 0x2 -> regfile receives only 0x2 for r9; popped entry yields write_en=0.
REQ-036 Zero register: pipe write addr 0 data 0xFFFF -> write_en=0 next cycle.
REQ-037 Reset mid-run: queue holding 2 entries, rst=0 one cycle -> no write_en afterwards, ll_ready=1, pipe_stall=0.
